alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Parametrised successor to the combinational ALU control decoder. Decodes ALUOp/Funct7/Funct3 into the full RV32I/RV64I integer op set plus an unsigned M-subset. Executes the decoded op behind a valid/ready handshake with a registered result. Single-cycle ops complete in one cycle; multiply/divide run on an iterative shift-add / restoring-divide datapath. Sits between ID/EX operand latch and the EX/MEM register, replacing the decoder + ALU pair.

## Interface
- XLEN, 32, operand/result width; legal values 32 or 64
- MULDIV_EN, 1, 1 enables MUL/MULHU/DIVU/REMU; 0 makes them illegal
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit accepts request this cycle
- ALUOp  in  2  00 add, 01 sub, 10 R-type, 11 I-type
- Funct7  in  7  instruction funct7 (I-type: imm[11:5])
- Funct3  in  3  instruction funct3
- a  in  XLEN  operand A (rs1)
- b  in  XLEN  operand B (rs2 or sign-extended immediate)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  registered result
- zero  out  1  registered result == 0
- illegal  out  1  registered; op undecodable

## Operation
- Decode (ALUOp=10, {Funct7,Funct3}): 0000000/000 ADD, 0100000/000 SUB, 0000000/111 AND, /110 OR, /100 XOR, /001 SLL, /101 SRL, 0100000/101 SRA, 0000000/010 SLT, /011 SLTU; 0000001/000 MUL, /011 MULHU, /101 DIVU, /111 REMU (only if MULDIV_EN). Anything else illegal.
- ALUOp=11: Funct3 selects ADDI/SLTI/SLTIU/XORI/ORI/ANDI ignoring Funct7; SLLI needs Funct7=0000000; SRLI/SRAI need Funct7 0000000/0100000, bit 0 of Funct7 ignored when XLEN=64. Otherwise illegal.
- ALUOp=00 ADD, 01 SUB regardless of funct fields.
- Shift amount = b[$clog2(XLEN)-1:0]. SLT signed, SLTU unsigned, result 0/1 zero-extended. All arithmetic mod 2^XLEN.
- MUL = low XLEN of a*b; MULHU = high XLEN of unsigned 2*XLEN product.
- DIVU/REMU unsigned; b==0: DIVU = all ones, REMU = a, illegal=0.
- Illegal op: accepted, completes as single-cycle op, result=0, zero=1, illegal=1.
- FSM: IDLE (accepts), BUSY (iterating, counter 0..XLEN-1). Output register holds result independently of FSM.
  - IDLE + accept single-cycle op: load output register, stay IDLE.
  - IDLE + accept M op: latch operands, BUSY, count=0.
  - BUSY: one iteration per cycle; at count=XLEN-1 load output register, return IDLE.
- in_ready = !rst & state==IDLE & (!out_valid | out_ready).
- out_valid clears on out_ready & !new load; new load in same cycle keeps it high with new data.

## Timing
- Reset (rst high at edge): state IDLE, out_valid=0, result=0, zero=0, illegal=0, counter=0; in_ready=0 while rst high. Reset mid-BUSY aborts op, result discarded.
- Handshake: transfer when valid & ready on same edge. Inputs sampled only at accept; may change afterward.
- Single-cycle latency: accept at edge N -> out_valid high after edge N; throughput 1/cycle with out_ready held high.
- M-op latency: accept at edge N -> out_valid high after edge N+XLEN; in_ready low for edges N+1..N+XLEN.
- Backpressure: out_ready low holds result/zero/illegal/out_valid stable; in_ready low until drained.
- out_ready high on same edge the next result loads: old result retires, new one presented, no bubble.

## Test plan
- ADD a=0x7FFFFFFF b=1, SUB a=5 b=5 (XLEN=32) -> result 0x80000000 zero=0 after 1 cycle; then result 0 zero=1.
- SRA a=0x80000000 b=0x24; SLT a=0xFFFFFFFF b=1; SLTU same -> 0xF8000000, 1, 0; back-to-back with out_ready=1 gives one result per cycle.
- MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE after 32 cycles, in_ready low throughout; MUL gives 0x00000001.
- DIVU a=100 b=7 -> 14; REMU -> 2; DIVU b=0 -> 0xFFFFFFFF; REMU b=0 a=9 -> 9, illegal=0.
- {Funct7,Funct3}=0000001/000 with MULDIV_EN=0, and 0100000/111 -> illegal=1 result=0 zero=1 after 1 cycle.
- Assert rst during BUSY -> next cycle out_valid=0, in_ready=1 after rst drops; out_ready=0 for 5 cycles holds result and out_valid stable.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Integer execute unit: decodes ALUOp/Funct7/Funct3 and executes behind a valid/ready handshake.
// S_IDLE | accepts requests, single-cycle ops load the output register directly
// S_BUSY | iterating shift-add multiply or restoring divide, one step per cycle
module alu_exec_unit #(
  parameter int XLEN      = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_MUL, OP_MULHU, OP_DIVU, OP_REMU, OP_ILL
  } op_e;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  op_e             mop_q;
  logic [XLEN-1:0] acc_q, lo_q, opnd_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q, illegal_q, out_valid_q;

  op_e             op;
  logic            is_mop, is_div_in, accept, fin, ld, ld_ill;
  logic [6:0]      f7_sh;
  logic [CW-1:0]   shamt;
  logic [XLEN-1:0] alu_res, fin_res, ld_val, acc_d, lo_d;
  logic [XLEN:0]   mul_sum, div_rsh, div_sub;
  logic            div_ge, out_valid_d;

  // On RV64 Funct7[0] carries shamt[5] for the immediate right shifts
  assign f7_sh = (XLEN == 64) ? {Funct7[6:1], 1'b0} : Funct7;

  always_comb begin
    op = OP_ILL;
    case (ALUOp)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        case ({Funct7, Funct3})
          {7'b0000000, 3'b000}: op = OP_ADD;
          {7'b0100000, 3'b000}: op = OP_SUB;
          {7'b0000000, 3'b111}: op = OP_AND;
          {7'b0000000, 3'b110}: op = OP_OR;
          {7'b0000000, 3'b100}: op = OP_XOR;
          {7'b0000000, 3'b001}: op = OP_SLL;
          {7'b0000000, 3'b101}: op = OP_SRL;
          {7'b0100000, 3'b101}: op = OP_SRA;
          {7'b0000000, 3'b010}: op = OP_SLT;
          {7'b0000000, 3'b011}: op = OP_SLTU;
          {7'b0000001, 3'b000}: op = MULDIV_EN ? OP_MUL   : OP_ILL;
          {7'b0000001, 3'b011}: op = MULDIV_EN ? OP_MULHU : OP_ILL;
          {7'b0000001, 3'b101}: op = MULDIV_EN ? OP_DIVU  : OP_ILL;
          {7'b0000001, 3'b111}: op = MULDIV_EN ? OP_REMU  : OP_ILL;
          default:              op = OP_ILL;
        endcase
      end
      2'b11: begin
        case (Funct3)
          3'b000: op = OP_ADD;
          3'b010: op = OP_SLT;
          3'b011: op = OP_SLTU;
          3'b100: op = OP_XOR;
          3'b110: op = OP_OR;
          3'b111: op = OP_AND;
          3'b001: op = (Funct7 == 7'b0000000) ? OP_SLL : OP_ILL;
          3'b101: begin
            if (f7_sh == 7'b0000000)      op = OP_SRL;
            else if (f7_sh == 7'b0100000) op = OP_SRA;
            else                          op = OP_ILL;
          end
          default: op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
  end

  assign is_mop    = op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
  assign is_div_in = op inside {OP_DIVU, OP_REMU};
  assign shamt     = b[CW-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  // acc_q is the product high half / partial remainder; lo_q the multiplier / quotient
  always_comb begin
    mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_rsh = {acc_q, lo_q[XLEN-1]};
    div_sub = div_rsh - {1'b0, opnd_q};
    div_ge  = div_rsh >= {1'b0, opnd_q};
    if (mop_q == OP_DIVU || mop_q == OP_REMU) begin
      acc_d = XLEN'(div_ge ? div_sub : div_rsh);
      lo_d  = {lo_q[XLEN-2:0], div_ge};
    end else begin
      acc_d = mul_sum[XLEN:1];
      lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    fin_res = (mop_q == OP_MUL || mop_q == OP_DIVU) ? lo_d : acc_d;
  end

  assign in_ready    = !rst && state_q == S_IDLE && (!out_valid_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign fin         = state_q == S_BUSY && cnt_q == CW'(XLEN-1);
  assign ld          = (accept && !is_mop) || fin;
  assign ld_val      = fin ? fin_res : alu_res;
  assign ld_ill      = !fin && op == OP_ILL;
  assign out_valid_d = ld || (out_valid_q && !out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mop_q       <= OP_MUL;
      acc_q       <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && is_mop) begin
            state_q <= S_BUSY;
            cnt_q   <= '0;
            mop_q   <= op;
            acc_q   <= '0;
            lo_q    <= is_div_in ? a : b;
            opnd_q  <= is_div_in ? b : a;
          end
        end
        S_BUSY: begin
          acc_q <= acc_d;
          lo_q  <= lo_d;
          if (fin) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (ld) begin
        result_q  <= ld_val;
        zero_q    <= ld_val == '0;
        illegal_q <= ld_ill;
      end
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, handshake corner sequences and random ops vs a reference model.
module tb_alu_exec_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, in_valid, out_ready;
  logic [1:0]      ALUOp;
  logic [6:0]      Funct7;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] a, b;
  logic            in_ready, out_valid, zero, illegal;
  logic [XLEN-1:0] result;
  logic            nm_in_ready, nm_out_valid, nm_zero, nm_illegal;
  logic [XLEN-1:0] nm_result;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.XLEN(XLEN), .MULDIV_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal)
  );

  alu_exec_unit #(.XLEN(XLEN), .MULDIV_EN(1'b0)) dut_nm (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nm_in_ready),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .a(a), .b(b),
    .out_valid(nm_out_valid), .out_ready(1'b1), .result(nm_result),
    .zero(nm_zero), .illegal(nm_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] x, input logic [31:0] y, input logic [31:0] r,
                         input bit ill, input int lat);
    vec_t v;
    v.op = op; v.f7 = f7; v.f3 = f3; v.a = x; v.b = y; v.res = r; v.ill = ill; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Reference semantics straight from the instruction definitions
  task automatic model(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output bit ill, output bit mop);
    logic [63:0] p;
    int sh;
    p = {32'd0, x} * {32'd0, y};
    sh = int'(y[4:0]);
    r = '0; ill = 1'b0; mop = 1'b0;
    case (op)
      2'd0: r = x + y;
      2'd1: r = x - y;
      2'd2: begin
        case ({f7, f3})
          {7'h00, 3'd0}: r = x + y;
          {7'h20, 3'd0}: r = x - y;
          {7'h00, 3'd7}: r = x & y;
          {7'h00, 3'd6}: r = x | y;
          {7'h00, 3'd4}: r = x ^ y;
          {7'h00, 3'd1}: r = x << sh;
          {7'h00, 3'd5}: r = x >> sh;
          {7'h20, 3'd5}: r = $signed(x) >>> sh;
          {7'h00, 3'd2}: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
          {7'h00, 3'd3}: r = (x < y) ? 32'd1 : 32'd0;
          {7'h01, 3'd0}: begin r = p[31:0];  mop = 1'b1; end
          {7'h01, 3'd3}: begin r = p[63:32]; mop = 1'b1; end
          {7'h01, 3'd5}: begin r = (y == 0) ? 32'hFFFF_FFFF : x / y; mop = 1'b1; end
          {7'h01, 3'd7}: begin r = (y == 0) ? x : x % y; mop = 1'b1; end
          default: ill = 1'b1;
        endcase
      end
      default: begin
        case (f3)
          3'd0: r = x + y;
          3'd2: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
          3'd3: r = (x < y) ? 32'd1 : 32'd0;
          3'd4: r = x ^ y;
          3'd6: r = x | y;
          3'd7: r = x & y;
          3'd1: if (f7 == 7'h00) r = x << sh; else ill = 1'b1;
          default: begin
            if (f7 == 7'h00)      r = x >> sh;
            else if (f7 == 7'h20) r = $signed(x) >>> sh;
            else                  ill = 1'b1;
          end
        endcase
      end
    endcase
    if (ill) r = '0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] x, input logic [31:0] y, input logic [31:0] er,
                        input bit eill, input int elat, input string nm);
    int w;
    int lat;
    bit rdy_bad;
    @(negedge clk);
    ALUOp = op; Funct7 = f7; Funct3 = f3; a = x; b = y; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk({nm, "_accept_timeout"}, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ALUOp = 2'($urandom); Funct7 = 7'($urandom); Funct3 = 3'($urandom);
    a = $urandom; b = $urandom;
    lat = 0;
    rdy_bad = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk({nm, "_result"}, result, er);
    chk({nm, "_zero"}, zero, (er == 0));
    chk({nm, "_illegal"}, illegal, eill);
    chk({nm, "_latency"}, lat, elat);
    if (elat > 0) chk({nm, "_busy_ready_low"}, rdy_bad, 1'b0);
  endtask

  initial begin : main
    logic [31:0] er;
    bit eill, mop;
    logic [1:0]  bop[3];
    logic [6:0]  bf7[3];
    logic [2:0]  bf3[3];
    logic [31:0] bres[3];
    bit seen;
    int w;

    add_vec(2'b00, 7'h00, 3'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 0);
    add_vec(2'b01, 7'h00, 3'd0, 32'd5, 32'd5, 32'h0, 1'b0, 0);
    add_vec(2'b10, 7'h20, 3'd5, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 0);
    add_vec(2'b10, 7'h00, 3'd2, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 0);
    add_vec(2'b10, 7'h00, 3'd3, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 0);
    add_vec(2'b10, 7'h01, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 32);
    add_vec(2'b10, 7'h01, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32);
    add_vec(2'b10, 7'h01, 3'd5, 32'd100, 32'd7, 32'd14, 1'b0, 32);
    add_vec(2'b10, 7'h01, 3'd7, 32'd100, 32'd7, 32'd2, 1'b0, 32);
    add_vec(2'b10, 7'h01, 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b0, 32);
    add_vec(2'b10, 7'h01, 3'd7, 32'd9, 32'd0, 32'd9, 1'b0, 32);
    add_vec(2'b10, 7'h20, 3'd7, 32'h1234, 32'h5678, 32'h0, 1'b1, 0);
    add_vec(2'b11, 7'h20, 3'd5, 32'h8000_0000, 32'h0000_0404, 32'hF800_0000, 1'b0, 0);
    add_vec(2'b11, 7'h01, 3'd1, 32'h1, 32'h1, 32'h0, 1'b1, 0);
    add_vec(2'b11, 7'h7F, 3'd0, 32'd10, 32'hFFFF_FFFF, 32'd9, 1'b0, 0);
    add_vec(2'b10, 7'h00, 3'd1, 32'h1, 32'h3F, 32'h8000_0000, 1'b0, 0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ALUOp = '0; Funct7 = '0; Funct3 = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].op, vecs[i].f7, vecs[i].f3, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].ill, vecs[i].lat, $sformatf("vec%0d", i));

    // Back-to-back single-cycle ops with out_ready held high
    bop[0] = 2'b10; bf7[0] = 7'h20; bf3[0] = 3'd5; bres[0] = 32'hF800_0000;
    bop[1] = 2'b10; bf7[1] = 7'h00; bf3[1] = 3'd2; bres[1] = 32'h1;
    bop[2] = 2'b10; bf7[2] = 7'h00; bf3[2] = 3'd3; bres[2] = 32'h0;
    @(negedge clk);
    ALUOp = bop[0]; Funct7 = bf7[0]; Funct3 = bf3[0];
    a = 32'h8000_0000; b = 32'h24; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("b2b_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      if (i < 2) begin
        ALUOp = bop[i+1]; Funct7 = bf7[i+1]; Funct3 = bf3[i+1];
        a = 32'hFFFF_FFFF; b = 32'h1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("b2b_out_valid", out_valid, 1'b1);
      chk("b2b_result", result, bres[i]);
    end

    // Backpressure: result held, second request waits, then retires with no bubble
    @(negedge clk);
    out_ready = 1'b0;
    ALUOp = 2'b00; a = 32'd1; b = 32'd2; in_valid = 1'b1;
    @(posedge clk);
    #1;
    ALUOp = 2'b01; a = 32'd10; b = 32'd3;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_result", result, 32'd3);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_nobubble_valid", out_valid, 1'b1);
    chk("bp_nobubble_result", result, 32'd7);

    // Reset while BUSY aborts the multiply
    @(negedge clk);
    ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'd3;
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_in_ready_in_rst", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1'b1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_discarded", seen, 1'b0);
    chk("abort_result", result, 32'h0);

    // M op with MULDIV_EN=0 is illegal and single-cycle
    @(negedge clk);
    ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'd0; a = 32'd3; b = 32'd5; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("nomd_out_valid", nm_out_valid, 1'b1);
    chk("nomd_illegal", nm_illegal, 1'b1);
    chk("nomd_result", nm_result, 32'h0);
    chk("nomd_zero", nm_zero, 1'b1);
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("md_mul_result", result, 32'd15);
    chk("md_mul_illegal", illegal, 1'b0);

    for (int n = 0; n < 200; n++) begin
      logic [1:0]  rop;
      logic [6:0]  rf7;
      logic [2:0]  rf3;
      logic [31:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: rf7 = 7'h00;
        1: rf7 = 7'h20;
        2: rf7 = 7'h01;
        default: rf7 = 7'($urandom);
      endcase
      rf3 = 3'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      model(rop, rf7, rf3, ra, rb, er, eill, mop);
      run_op(rop, rf7, rf3, ra, rb, er, eill, mop ? 32 : 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
